alu_op_issue: RTL and testbench
===============================

# alu_op_issue

Issue stage on the driving side of the ALU op-code interface. It decodes a 32-bit MIPS instruction into the 4-bit ALU operation code and selects and extends the two ALU operands: register data, shift amount or immediate. It holds all of this in a stall/flush-capable pipeline register that feeds the EX-stage ALU directly. Illegal encodings are flagged and issued as bubbles.

## Interface
Parameters:
- NB_REG, 32, datapath width (operands, register data)
- NB_ALU_CTRLI, 4, ALU op-code width
- NB_INSTR, 32, instruction width

Ports:
- i_clock  in  1  single clock, rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_valid  in  1  instruction/operands valid this cycle
- i_instr  in  NB_INSTR  instruction word
- i_rs_data  in  NB_REG  rs register value
- i_rt_data  in  NB_REG  rt register value
- i_stall  in  1  hold the output register
- i_flush  in  1  kill the output register contents
- o_valid  out  1  registered: ALU inputs below are meaningful
- o_op_code  out  NB_ALU_CTRLI  registered ALU operation
- o_a  out  NB_REG  registered ALU operand A
- o_b  out  NB_REG  registered ALU operand B
- o_illegal  out  1  registered one-cycle pulse: illegal instruction accepted
- o_illegal_count  out  16  illegal-instruction count (only with macro, see Configuration)

## Operation
- ALU codes: SLL=0000, SRL=0001, SRA=0010, ADD=0011, SUB=0100, AND=0101, OR=0110, XOR=0111, NOR=1000, SLT=1001, SLL16=1101, EQ=1110, NEQ=1111.
- Extension rules: sext = sign-extend imm[15:0] to NB_REG; zext = zero-extend; shamt = zero-extended instr[10:6].
- R-type decode (opcode 000000), by funct:
  - SLL/SRL/SRA (000000/000010/000011): op SLL/SRL/SRA, a=rt, b=shamt.
  - SLLV/SRLV/SRAV (000100/000110/000111): op SLL/SRL/SRA, a=rt, b=rs.
  - ADDU 100001 → ADD; SUBU 100011 → SUB; AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010 → matching op. All with a=rs, b=rt.
  - JR 001000, JALR 001001: op ADD, a=rs, b=0.
- I-type decode, by opcode:
  - ADDI 001000, ADDIU 001001, SLTI 001010: ADD/ADD/SLT, a=rs, b=sext.
  - ANDI 001100, ORI 001101, XORI 001110: AND/OR/XOR, a=rs, b=zext.
  - LUI 001111: op SLL16, a=zext, b=0.
  - BEQ 000100 → EQ; BNE 000101 → NEQ. Both with a=rs, b=rt.
  - Loads 100000–100111 and stores 101000–101011: op ADD, a=rs, b=sext.
- J 000010 and JAL 000011 are legal: op ADD, a=0, b=0.
- Any other encoding is illegal: it loads with o_valid=0 and o_op_code/o_a/o_b=0, and sets o_illegal=1 for one cycle.
- Register update priority, per cycle: flush > stall > load.
  - flush: o_valid=0 and o_illegal=0; other outputs hold.
  - stall: all outputs hold, except o_illegal, which drops to 0.
  - load: all outputs take the decode of the inputs. With i_valid=0, o_valid=0 and o_illegal=0.

## Timing
- Latency: 1 cycle from i_instr/i_valid to o_*. No combinational input→output path.
- Reset (asynchronous assert, synchronous release): o_valid=0, o_op_code=0, o_a=0, o_b=0, o_illegal=0, o_illegal_count=0.
- Reset during a stall discards the held instruction.
- Simultaneous i_flush and i_stall: flush wins, and o_valid is 0 next cycle.
- An illegal instruction presented while stalled is not counted or flagged until it is actually loaded.
- Back-to-back valid instructions with no stall: one issue per cycle.

## Configuration
- Macro ALU_ISSUE_ILLEGAL_CNT_EN.
- Defined: o_illegal_count exists. It increments by 1 on every cycle in which o_illegal is being set, and saturates at 16'hFFFF (no wrap). It is cleared only by reset.
- Undefined: the port and counter are absent, and the remaining behaviour is identical.

## Structure
- Package alu_op_pkg holds:
  - the ALU op-code localparams listed above (shared with the ALU);
  - the opcode/funct constants;
  - the extension-type enum (SEXT, ZEXT, SHAMT, ZERO, REG).
- Sub-module alu_op_decode holds the purely combinational instruction → {legal, op_code, a_sel, b_sel} decode. The top holds operand muxing, the pipeline register and the counter.

## Test plan
- ADDI with rs=0x00000005, imm=0xFFFF, i_valid=1 → next cycle o_valid=1, o_op_code=0011, o_a=5, o_b=0xFFFFFFFF.
- SRA with rt=0x80000000, shamt=4 → o_op_code=0010, o_a=0x80000000, o_b=4. LUI with imm=0x1234 → o_op_code=1101, o_a=0x00001234, o_b=0.
- ORI with imm=0x8001 → o_b=0x00008001 (zero-extended). BNE → o_op_code=1111, o_a=rs, o_b=rt.
- Load ADD, then i_stall=1 for 3 cycles while i_instr changes → outputs frozen. Then assert i_stall=1 and i_flush=1 together → o_valid=0 next cycle.
- Opcode 111111 with i_valid=1 → o_valid=0, o_illegal pulse of exactly 1 cycle. With the macro defined, o_illegal_count goes 0→1. After 65536 illegal instructions it reads 0xFFFF.
- Assert i_reset_n=0 mid-stream while o_valid=1 → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_op_pkg.sv
// Shared ALU op-code constants, MIPS opcode/funct encodings and operand-select enum
// for the issue stage and the EX-stage ALU.
package alu_op_pkg;

    localparam logic [3:0] ALU_SLL   = 4'b0000;
    localparam logic [3:0] ALU_SRL   = 4'b0001;
    localparam logic [3:0] ALU_SRA   = 4'b0010;
    localparam logic [3:0] ALU_ADD   = 4'b0011;
    localparam logic [3:0] ALU_SUB   = 4'b0100;
    localparam logic [3:0] ALU_AND   = 4'b0101;
    localparam logic [3:0] ALU_OR    = 4'b0110;
    localparam logic [3:0] ALU_XOR   = 4'b0111;
    localparam logic [3:0] ALU_NOR   = 4'b1000;
    localparam logic [3:0] ALU_SLT   = 4'b1001;
    localparam logic [3:0] ALU_SLL16 = 4'b1101;
    localparam logic [3:0] ALU_EQ    = 4'b1110;
    localparam logic [3:0] ALU_NEQ   = 4'b1111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_JALR = 6'b001001;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    // Operand source; register reads are split into rs and rt because shifts take rt on A.
    typedef enum logic [2:0] {
        SEXT,
        ZEXT,
        SHAMT,
        ZERO,
        REG_RS,
        REG_RT
    } ext_t;

    // Loads occupy 100000-100111, stores 101000-101011; both compute base + offset.
    function automatic logic is_mem_op(input logic [5:0] opcode);
        return (opcode[5:3] == 3'b100) || (opcode[5:2] == 4'b1010);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Purely combinational MIPS opcode/funct decode into ALU op-code and operand selects.
// Illegal encodings return op_code 0 with both operands selecting ZERO.
module alu_op_decode
    import alu_op_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       legal,
    output logic [3:0] op_code,
    output ext_t       a_sel,
    output ext_t       b_sel
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the cases can infer a latch.
        legal   = 1'b1;
        op_code = ALU_ADD;
        a_sel   = REG_RS;
        b_sel   = REG_RT;

        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_SLL:  begin op_code = ALU_SLL; a_sel = REG_RT; b_sel = SHAMT;  end
                FN_SRL:  begin op_code = ALU_SRL; a_sel = REG_RT; b_sel = SHAMT;  end
                FN_SRA:  begin op_code = ALU_SRA; a_sel = REG_RT; b_sel = SHAMT;  end
                FN_SLLV: begin op_code = ALU_SLL; a_sel = REG_RT; b_sel = REG_RS; end
                FN_SRLV: begin op_code = ALU_SRL; a_sel = REG_RT; b_sel = REG_RS; end
                FN_SRAV: begin op_code = ALU_SRA; a_sel = REG_RT; b_sel = REG_RS; end
                FN_JR, FN_JALR: b_sel = ZERO;
                FN_ADDU: op_code = ALU_ADD;
                FN_SUBU: op_code = ALU_SUB;
                FN_AND:  op_code = ALU_AND;
                FN_OR:   op_code = ALU_OR;
                FN_XOR:  op_code = ALU_XOR;
                FN_NOR:  op_code = ALU_NOR;
                FN_SLT:  op_code = ALU_SLT;
                default: legal = 1'b0;
            endcase
        end else begin
            case (opcode)
                OP_ADDI, OP_ADDIU: b_sel = SEXT;
                OP_SLTI: begin op_code = ALU_SLT; b_sel = SEXT; end
                OP_ANDI: begin op_code = ALU_AND; b_sel = ZEXT; end
                OP_ORI:  begin op_code = ALU_OR;  b_sel = ZEXT; end
                OP_XORI: begin op_code = ALU_XOR; b_sel = ZEXT; end
                OP_LUI:  begin op_code = ALU_SLL16; a_sel = ZEXT; b_sel = ZERO; end
                OP_BEQ:  op_code = ALU_EQ;
                OP_BNE:  op_code = ALU_NEQ;
                OP_J, OP_JAL: begin a_sel = ZERO; b_sel = ZERO; end
                default: begin
                    if (is_mem_op(opcode)) b_sel = SEXT;
                    else                   legal = 1'b0;
                end
            endcase
        end

        if (!legal) begin
            op_code = '0;
            a_sel   = ZERO;
            b_sel   = ZERO;
        end
    end

endmodule

// File: rtl/alu_op_issue.sv
// ALU issue stage: decode, operand select/extend and stall/flush pipeline register.
// Optional macro ALU_ISSUE_ILLEGAL_CNT_EN adds the saturating o_illegal_count output.
module alu_op_issue
    import alu_op_pkg::*;
#(
    parameter int NB_REG       = 32,
    parameter int NB_ALU_CTRLI = 4,
    parameter int NB_INSTR     = 32
) (
    input  logic                    i_clock,
    input  logic                    i_reset_n,
    input  logic                    i_valid,
    input  logic [NB_INSTR-1:0]     i_instr,
    input  logic [NB_REG-1:0]       i_rs_data,
    input  logic [NB_REG-1:0]       i_rt_data,
    input  logic                    i_stall,
    input  logic                    i_flush,
    output logic                    o_valid,
    output logic [NB_ALU_CTRLI-1:0] o_op_code,
    output logic [NB_REG-1:0]       o_a,
    output logic [NB_REG-1:0]       o_b,
    output logic                    o_illegal
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
    ,
    output logic [15:0]             o_illegal_count
`endif
);

    logic        dec_legal;
    logic [3:0]  dec_op_code;
    ext_t        a_sel;
    ext_t        b_sel;
    logic [NB_REG-1:0] imm_sext, imm_zext, shamt, a_mux, b_mux;
    logic        load_en;
    logic        unused_reg_fields;

    alu_op_decode u_decode (
        .opcode  (i_instr[31:26]),
        .funct   (i_instr[5:0]),
        .legal   (dec_legal),
        .op_code (dec_op_code),
        .a_sel   (a_sel),
        .b_sel   (b_sel)
    );

    // Register specifiers are resolved upstream; only their data arrives here.
    assign unused_reg_fields = ^i_instr[25:16];

    assign imm_sext = {{(NB_REG-16){i_instr[15]}}, i_instr[15:0]};
    assign imm_zext = {{(NB_REG-16){1'b0}}, i_instr[15:0]};
    assign shamt    = {{(NB_REG-5){1'b0}}, i_instr[10:6]};

    always_comb begin
        a_mux = '0;
        b_mux = '0;
        case (a_sel)
            SEXT:    a_mux = imm_sext;
            ZEXT:    a_mux = imm_zext;
            SHAMT:   a_mux = shamt;
            REG_RS:  a_mux = i_rs_data;
            REG_RT:  a_mux = i_rt_data;
            default: a_mux = '0;
        endcase
        case (b_sel)
            SEXT:    b_mux = imm_sext;
            ZEXT:    b_mux = imm_zext;
            SHAMT:   b_mux = shamt;
            REG_RS:  b_mux = i_rs_data;
            REG_RT:  b_mux = i_rt_data;
            default: b_mux = '0;
        endcase
    end

    assign load_en = !i_flush && !i_stall;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!i_reset_n) begin
            o_valid   <= 1'b0;
            o_op_code <= '0;
            o_a       <= '0;
            o_b       <= '0;
            o_illegal <= 1'b0;
        end else if (i_flush) begin
            o_valid   <= 1'b0;
            o_illegal <= 1'b0;
        end else if (i_stall) begin
            o_illegal <= 1'b0;
        end else begin
            o_valid   <= i_valid && dec_legal;
            o_op_code <= NB_ALU_CTRLI'(dec_op_code);
            o_a       <= a_mux;
            o_b       <= b_mux;
            o_illegal <= i_valid && !dec_legal;
        end
    end

`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_illegal_count <= '0;
        end else if (load_en && i_valid && !dec_legal && (o_illegal_count != 16'hFFFF)) begin
            o_illegal_count <= o_illegal_count + 16'd1;
        end
    end
`else
    logic unused_load_en;
    assign unused_load_en = load_en;
`endif

endmodule

// File: tb/tb_alu_op_issue.sv
// Self-checking bench for alu_op_issue: behavioural model plus directed literal checks
// and randomized stimulus. Counter checks apply when ALU_ISSUE_ILLEGAL_CNT_EN is defined.
module tb_alu_op_issue;

    logic        i_clock = 1'b0;
    logic        i_reset_n;
    logic        i_valid;
    logic [31:0] i_instr;
    logic [31:0] i_rs_data;
    logic [31:0] i_rt_data;
    logic        i_stall;
    logic        i_flush;
    logic        o_valid;
    logic [3:0]  o_op_code;
    logic [31:0] o_a;
    logic [31:0] o_b;
    logic        o_illegal;
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
    logic [15:0] o_illegal_count;
`endif

    alu_op_issue dut (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_valid   (i_valid),
        .i_instr   (i_instr),
        .i_rs_data (i_rs_data),
        .i_rt_data (i_rt_data),
        .i_stall   (i_stall),
        .i_flush   (i_flush),
        .o_valid   (o_valid),
        .o_op_code (o_op_code),
        .o_a       (o_a),
        .o_b       (o_b),
        .o_illegal (o_illegal)
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
        ,
        .o_illegal_count (o_illegal_count)
`endif
    );

    always #5 i_clock = ~i_clock;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode written straight from the instruction-set table.
    task automatic model_decode(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                                output bit legal, output logic [3:0] op,
                                output logic [31:0] a, output logic [31:0] b);
        logic [5:0]  opc;
        logic [5:0]  fn;
        logic [31:0] sx, zx, sh;
        opc = ins[31:26];
        fn  = ins[5:0];
        sx  = {{16{ins[15]}}, ins[15:0]};
        zx  = {16'h0, ins[15:0]};
        sh  = {27'h0, ins[10:6]};
        legal = 1'b1;
        op = 4'd0; a = 32'h0; b = 32'h0;
        if (opc == 6'd0) begin
            case (fn)
                6'h00: begin op = 4'd0; a = rt; b = sh; end
                6'h02: begin op = 4'd1; a = rt; b = sh; end
                6'h03: begin op = 4'd2; a = rt; b = sh; end
                6'h04: begin op = 4'd0; a = rt; b = rs; end
                6'h06: begin op = 4'd1; a = rt; b = rs; end
                6'h07: begin op = 4'd2; a = rt; b = rs; end
                6'h08, 6'h09: begin op = 4'd3; a = rs; b = 32'h0; end
                6'h21: begin op = 4'd3; a = rs; b = rt; end
                6'h23: begin op = 4'd4; a = rs; b = rt; end
                6'h24: begin op = 4'd5; a = rs; b = rt; end
                6'h25: begin op = 4'd6; a = rs; b = rt; end
                6'h26: begin op = 4'd7; a = rs; b = rt; end
                6'h27: begin op = 4'd8; a = rs; b = rt; end
                6'h2A: begin op = 4'd9; a = rs; b = rt; end
                default: legal = 1'b0;
            endcase
        end else begin
            case (opc)
                6'h08, 6'h09: begin op = 4'd3; a = rs; b = sx; end
                6'h0A: begin op = 4'd9; a = rs; b = sx; end
                6'h0C: begin op = 4'd5; a = rs; b = zx; end
                6'h0D: begin op = 4'd6; a = rs; b = zx; end
                6'h0E: begin op = 4'd7; a = rs; b = zx; end
                6'h0F: begin op = 4'd13; a = zx; b = 32'h0; end
                6'h04: begin op = 4'd14; a = rs; b = rt; end
                6'h05: begin op = 4'd15; a = rs; b = rt; end
                6'h02, 6'h03: begin op = 4'd3; a = 32'h0; b = 32'h0; end
                default: begin
                    if (opc >= 6'h20 && opc <= 6'h2B) begin op = 4'd3; a = rs; b = sx; end
                    else legal = 1'b0;
                end
            endcase
        end
        if (!legal) begin
            op = 4'd0; a = 32'h0; b = 32'h0;
        end
    endtask

    bit          m_valid;
    bit          m_ill;
    logic [3:0]  m_op;
    logic [31:0] m_a;
    logic [31:0] m_b;
    int          m_cnt;

    always @(posedge i_clock or negedge i_reset_n) begin
        bit          lg;
        logic [3:0]  op;
        logic [31:0] a, b;
        if (!i_reset_n) begin
            m_valid = 0; m_ill = 0; m_op = 4'd0; m_a = 32'h0; m_b = 32'h0; m_cnt = 0;
        end else if (i_flush) begin
            m_valid = 0; m_ill = 0;
        end else if (i_stall) begin
            m_ill = 0;
        end else begin
            model_decode(i_instr, i_rs_data, i_rt_data, lg, op, a, b);
            m_valid = i_valid && lg;
            m_ill   = i_valid && !lg;
            m_op = op; m_a = a; m_b = b;
            if (m_ill && m_cnt < 65535) m_cnt++;
        end
    end

    always @(negedge i_clock) begin
        if (cmp_en && i_reset_n) begin
            check("cmp_valid", {31'h0, o_valid}, {31'h0, m_valid});
            check("cmp_op", {28'h0, o_op_code}, {28'h0, m_op});
            check("cmp_a", o_a, m_a);
            check("cmp_b", o_b, m_b);
            check("cmp_illegal", {31'h0, o_illegal}, {31'h0, m_ill});
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
            check("cmp_count", {16'h0, o_illegal_count}, m_cnt);
`endif
        end
    end

    task automatic drive(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                         input logic v, input logic st, input logic fl);
        i_instr = ins; i_rs_data = rs; i_rt_data = rt;
        i_valid = v; i_stall = st; i_flush = fl;
        @(negedge i_clock);
    endtask

    logic [5:0] fn_list [15] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                                 6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
    logic [5:0] op_list [12] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0C,
                                 6'h0D, 6'h0E, 6'h0F, 6'h23};

    initial begin
        logic [31:0] ins;
        int k;
        i_reset_n = 1'b0;
        i_valid = 0; i_instr = 32'h0; i_rs_data = 32'h0; i_rt_data = 32'h0;
        i_stall = 0; i_flush = 0;
        repeat (2) @(negedge i_clock);
        check("rst_valid", {31'h0, o_valid}, 32'h0);
        check("rst_op", {28'h0, o_op_code}, 32'h0);
        check("rst_a", o_a, 32'h0);
        check("rst_b", o_b, 32'h0);
        check("rst_illegal", {31'h0, o_illegal}, 32'h0);
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
        check("rst_count", {16'h0, o_illegal_count}, 32'h0);
`endif
        i_reset_n = 1'b1;
        cmp_en = 1'b1;

        // ADDI rs=5 imm=0xFFFF
        drive({6'h08, 5'd1, 5'd2, 16'hFFFF}, 32'h5, 32'hDEAD, 1, 0, 0);
        check("addi_valid", {31'h0, o_valid}, 32'h1);
        check("addi_op", {28'h0, o_op_code}, 32'h3);
        check("addi_a", o_a, 32'h5);
        check("addi_b", o_b, 32'hFFFF_FFFF);

        // SRA shamt=4, rt=0x80000000
        drive({6'h00, 5'd0, 5'd3, 5'd4, 5'd4, 6'h03}, 32'h1111, 32'h8000_0000, 1, 0, 0);
        check("sra_op", {28'h0, o_op_code}, 32'h2);
        check("sra_a", o_a, 32'h8000_0000);
        check("sra_b", o_b, 32'h4);

        // LUI imm=0x1234
        drive({6'h0F, 5'd0, 5'd1, 16'h1234}, 32'h7777, 32'h8888, 1, 0, 0);
        check("lui_op", {28'h0, o_op_code}, 32'hD);
        check("lui_a", o_a, 32'h0000_1234);
        check("lui_b", o_b, 32'h0);

        // ORI zero-extends
        drive({6'h0D, 5'd1, 5'd2, 16'h8001}, 32'h10, 32'h0, 1, 0, 0);
        check("ori_op", {28'h0, o_op_code}, 32'h6);
        check("ori_b", o_b, 32'h0000_8001);

        // BNE
        drive({6'h05, 5'd1, 5'd2, 16'h0010}, 32'hAAAA_5555, 32'h1234_5678, 1, 0, 0);
        check("bne_op", {28'h0, o_op_code}, 32'hF);
        check("bne_a", o_a, 32'hAAAA_5555);
        check("bne_b", o_b, 32'h1234_5678);

        // ADDU then 3-cycle stall with changing inputs
        drive({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, 32'h7, 32'h9, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive($urandom, $urandom, $urandom, 1, 1, 0);
            check("stall_valid", {31'h0, o_valid}, 32'h1);
            check("stall_op", {28'h0, o_op_code}, 32'h3);
            check("stall_a", o_a, 32'h7);
            check("stall_b", o_b, 32'h9);
        end
        drive({6'h08, 26'h0}, 32'h1, 32'h2, 1, 1, 1);
        check("flush_stall_valid", {31'h0, o_valid}, 32'h0);
        check("flush_hold_a", o_a, 32'h7);

        // Illegal opcode 111111
        drive({6'h3F, 26'h0}, 32'h55, 32'h66, 1, 0, 0);
        check("ill_valid", {31'h0, o_valid}, 32'h0);
        check("ill_pulse", {31'h0, o_illegal}, 32'h1);
        check("ill_op", {28'h0, o_op_code}, 32'h0);
        check("ill_a", o_a, 32'h0);
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
        check("ill_count1", {16'h0, o_illegal_count}, 32'h1);
`endif
        drive({6'h08, 26'h0}, 32'h1, 32'h2, 0, 0, 0);
        check("ill_pulse_end", {31'h0, o_illegal}, 32'h0);

        // Illegal presented while stalled: flagged only once loaded
        drive({6'h00, 20'h0, 6'h3F}, 32'h1, 32'h2, 1, 1, 0);
        drive({6'h00, 20'h0, 6'h3F}, 32'h1, 32'h2, 1, 1, 0);
        check("ill_stalled", {31'h0, o_illegal}, 32'h0);
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
        check("ill_stalled_count", {16'h0, o_illegal_count}, 32'h1);
`endif
        drive({6'h00, 20'h0, 6'h3F}, 32'h1, 32'h2, 1, 0, 0);
        check("ill_loaded", {31'h0, o_illegal}, 32'h1);

        // Asynchronous reset while stalled and valid
        drive({6'h09, 5'd1, 5'd2, 16'h0003}, 32'h100, 32'h0, 1, 0, 0);
        check("pre_rst_valid", {31'h0, o_valid}, 32'h1);
        i_stall = 1'b1;
        #2 i_reset_n = 1'b0;
        #1;
        check("async_valid", {31'h0, o_valid}, 32'h0);
        check("async_op", {28'h0, o_op_code}, 32'h0);
        check("async_a", o_a, 32'h0);
        check("async_b", o_b, 32'h0);
        @(negedge i_clock);
        i_reset_n = 1'b1;
        drive({6'h09, 5'd1, 5'd2, 16'h0003}, 32'h100, 32'h0, 0, 1, 0);
        check("rst_stall_discard", o_a, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            ins = $urandom;
            k = $urandom_range(0, 9);
            if (k < 4) begin
                ins[31:26] = 6'h00;
                if (k != 3) ins[5:0] = fn_list[$urandom_range(0, 14)];
            end else if (k < 8) begin
                ins[31:26] = op_list[$urandom_range(0, 11)];
            end
            drive(ins, $urandom, $urandom, ($urandom_range(0, 9) < 8),
                  ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 1));
        end

`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
        // Saturation
        for (int n = 0; n < 65536; n++) drive({6'h3F, 26'h0}, 32'h0, 32'h0, 1, 0, 0);
        check("sat_count", {16'h0, o_illegal_count}, 32'hFFFF);
        drive({6'h3F, 26'h0}, 32'h0, 32'h0, 1, 0, 0);
        check("sat_hold", {16'h0, o_illegal_count}, 32'hFFFF);
`endif

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
